// File: rtl/fft_twiddle_reader_if.sv
// Output stream of the twiddle reader: a registered (re, im) pair with a
// valid/ready handshake.
//   out_valid : source holds a valid beat on out_re/out_im
//   out_ready : sink accepts the beat when out_valid && out_ready
//   out_re    : real twiddle component
//   out_im    : imaginary twiddle component
// master = the reader (source), slave = the downstream consumer.
interface fft_twiddle_reader_if #(
   parameter int unsigned WIDTH = 32
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_re;
   logic [WIDTH-1:0] out_im;

   modport master (
      output out_valid,
      output out_re,
      output out_im,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_re,
      input  out_im,
      output out_ready
   );
endinterface

// File: rtl/fft_twiddle_reader.sv
// Fetches a burst of twiddle factors from a pair of combinational-read RAMs
// (re and im share one address) and streams them out as registered pairs.
// Addresses start at base_addr and step by stride, wrapping modulo DEPTH.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle burst request, honoured only when idle
//   base_addr, stride : first index and per-beat increment, sampled with start
//   count             : beats in the burst (0 allowed), sampled with start
//   ram_address       : shared read address for both RAMs
//   ram_re_data/im    : combinational RAM read data at ram_address
//   out_if            : valid/ready stream of (re, im) beats
//   busy              : burst in progress (RUN or DRAIN)
//   done              : one-cycle pulse when the burst has fully drained
module fft_twiddle_reader #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 360,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [AW-1:0]          base_addr,
   input  logic [AW-1:0]          stride,
   input  logic [CW-1:0]          count,
   output logic [AW-1:0]          ram_address,
   input  logic [WIDTH-1:0]       ram_re_data,
   input  logic [WIDTH-1:0]       ram_im_data,
   fft_twiddle_reader_if.master   out_if,
   output logic                   busy,
   output logic                   done
);

   localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

   state_e           state_q;
   logic [AW-1:0]    addr_q;
   logic [AW-1:0]    stride_q;
   logic [CW-1:0]    remaining_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_re_q;
   logic [WIDTH-1:0] out_im_q;
   logic             busy_q;
   logic             done_q;

   logic [AW:0]      addr_sum;
   logic [AW-1:0]    addr_next;
   logic             handshake;
   logic             capture;

   // One extra bit keeps the carry so the wrap test is exact; both operands
   // are below DEPTH, so one subtraction always lands back in range.
   always_comb begin
      addr_sum  = {1'b0, addr_q} + {1'b0, stride_q};
      addr_next = addr_sum[AW-1:0];
      if (addr_sum >= DepthW) begin
         addr_next = AW'(addr_sum - DepthW);
      end
   end

   assign handshake = out_valid_q && out_if.out_ready;
   // The output register may be refilled when empty or being emptied this cycle.
   assign capture   = (state_q == StRun) && (remaining_q != '0) &&
                      (!out_valid_q || out_if.out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         stride_q    <= '0;
         remaining_q <= '0;
         out_valid_q <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;

         // A consumed beat with nothing to replace it empties the register;
         // a simultaneous capture below overrides this.
         if (handshake && !capture) begin
            out_valid_q <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (start) begin
                  addr_q      <= base_addr;
                  stride_q    <= stride;
                  remaining_q <= count;
                  busy_q      <= 1'b1;
                  state_q     <= StRun;
               end
            end

            StRun: begin
               if (remaining_q == '0) begin
                  state_q <= StDrain;
               end else if (capture) begin
                  out_re_q    <= ram_re_data;
                  out_im_q    <= ram_im_data;
                  out_valid_q <= 1'b1;
                  remaining_q <= remaining_q - CW'(1);
                  addr_q      <= addr_next;
                  if (remaining_q == CW'(1)) begin
                     state_q <= StDrain;
                  end
               end
            end

            StDrain: begin
               // Finish once the last beat is gone or leaves this cycle.
               if (!out_valid_q || out_if.out_ready) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StFinish;
               end
            end

            StFinish: begin
               state_q <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign ram_address      = addr_q;
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_re    = out_re_q;
   assign out_if.out_im    = out_im_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule
